pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Controller for the program-counter/instruction-increment datapath. It owns the architectural PC and sequences instruction fetches over a valid/ready handshake to instruction memory. It selects the next PC from sequential increment, branch or jump, and holds on stall or disable. It sits between the branch/jump resolution logic and the instruction memory port, and feeds the fetched PC to decode.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  run enable; 0 = no new fetch requests
- stall  in  1  decode stall; hold PC, no new request
- branch_taken  in  1  one-cycle pulse, redirect to branch_target
- branch_target  in  32  branch destination
- jump  in  1  one-cycle pulse, redirect to jump_target; outranks branch_taken
- jump_target  in  32  jump destination
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  memory accepts request this cycle
- fetch_valid  out  1  one-cycle pulse: fetch_pc is a correct-path fetched PC
- fetch_pc  out  32  PC of the completed fetch
- pc_plus4  out  32  fetch_pc + 4, mod 2^32
- misaligned  out  1  sticky; a redirect target had nonzero bits [1:0]

## Operation
- State register values: IDLE, FETCH, STALL.
- IDLE: imem_req=0.
  - en=1 and stall=0: go to FETCH.
  - Redirect: pc := target.
- FETCH: imem_req=1, imem_addr=pc.
  - Handshake completes when imem_req & imem_ready.
  - On completion: pc := pc+4, or the pending/current redirect target.
  - Next state on completion: stall=1 → STALL; en=0 → IDLE; else stay in FETCH (back-to-back fetches).
  - No completion: hold imem_addr; stall and en do not drop the outstanding request.
- STALL: imem_req=0. Leave when stall=0: to FETCH if en=1, else IDLE.
- Redirect priority: jump > branch_taken > sequential.
- Target alignment: bits [1:0] of the target are forced to 00 before loading. If either bit was 1, set misaligned; it clears only on reset.
- Redirect while FETCH is outstanding:
  - Latch the target into pending_target and set pending=1.
  - A later redirect before completion overwrites the pending target, jump still outranking branch in the same cycle.
  - On completion: pc := pending_target, pending := 0, fetch_valid stays 0 (wrong-path fetch squashed).
- Redirect in the completion cycle: the same squash applies; pc := that target.
- Redirect in IDLE or STALL: pc := target, nothing is squashed.
- Arithmetic: unsigned 32-bit. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.

## Timing
- Values under reset (asynchronous, immediate):
  - pc = RESET_VECTOR, state = IDLE, pending = 0
  - imem_req = 0, imem_addr = RESET_VECTOR
  - fetch_valid = 0, fetch_pc = RESET_VECTOR, pc_plus4 = RESET_VECTOR + 4
  - misaligned = 0
- Reset mid-FETCH: the request is abandoned immediately (imem_req=0 asynchronously). Memory must ignore it.
- First request: en=1 in cycle N (after reset is released) → imem_req=1 in cycle N+1.
- Fetch latency: completion in cycle N → fetch_valid=1 and fetch_pc in cycle N+1; imem_addr = next pc in cycle N+1.
- Throughput: with imem_ready held at 1, one fetch per cycle.
- Redirect latency: target appears on imem_addr one cycle after the completion or pulse (IDLE/STALL case, once a request issues).
- fetch_valid is registered and never asserted two cycles for one handshake.
- Stall asserted in a completion cycle: the completion still produces fetch_valid next cycle. No new request until stall=0.

## Test plan
- Reset, then en=1, imem_ready=1 constant, RESET_VECTOR=0 → imem_addr 0,4,8,12 on consecutive cycles; fetch_valid pulses with fetch_pc 0,4,8 and pc_plus4 4,8,12.
- imem_ready low 3 cycles while imem_addr=8 → imem_addr holds 8, no fetch_valid. When ready rises: fetch_pc=8 next cycle, then imem_addr=12.
- Outstanding fetch at 0x10; branch_taken with target 0x100, then jump with target 0x200 before ready → completion gives no fetch_valid; next imem_addr=0x200.
- jump and branch_taken in the same cycle, in IDLE (targets 0x40 / 0x80) → next fetch at 0x40. Separately, target 0x43 → imem_addr 0x40, misaligned=1 and it remains 1.
- pc at 0xFFFF_FFFC, completion → fetch_pc=0xFFFF_FFFC, pc_plus4=0, next imem_addr=0.
- stall=1 during back-to-back fetches → imem_req drops after the in-flight completion and resumes the cycle after stall=0. Reset asserted mid-request → imem_req=0 and imem_addr=RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the architectural PC and sequences instruction fetches to instruction
// memory over a valid/ready handshake. The next PC is the sequential
// increment, a branch target or a jump target. The sequencer holds on stall or
// when run enable is low. A redirect that arrives while a fetch is outstanding
// squashes that (wrong-path) fetch when it completes.
//
// Ports
//   clk            system clock, all state on rising edge
//   reset          asynchronous active-high reset, clears all state
//   en             run enable; 0 = no new fetch requests
//   stall          decode stall; hold PC, no new request
//   branch_taken   one-cycle pulse, redirect to branch_target
//   branch_target  branch destination
//   jump           one-cycle pulse, redirect to jump_target (beats branch)
//   jump_target    jump destination
//   imem_req       fetch request valid
//   imem_addr      fetch address, stable while a request is outstanding
//   imem_ready     memory accepts the request this cycle
//   fetch_valid    one-cycle pulse: fetch_pc is a correct-path fetched PC
//   fetch_pc       PC of the completed fetch
//   pc_plus4       fetch_pc + 4 (mod 2^32)
//   misaligned     sticky: some redirect target had nonzero bits [1:0]
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] pc_plus4,
   output logic        misaligned
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   logic [1:0]  state, state_next;
   logic [31:0] pc, pc_next;
   logic        pending, pending_next;
   logic [31:0] pending_target, pending_target_next;
   logic        fetch_valid_next;
   logic [31:0] fetch_pc_next;

   logic        redirect;
   logic [31:0] redirect_raw;
   logic [31:0] redirect_target;

   // Jump outranks branch when both pulse in the same cycle.
   assign redirect        = jump | branch_taken;
   assign redirect_raw    = jump ? jump_target : branch_target;
   assign redirect_target = {redirect_raw[31:2], 2'b00};

   // The request is a pure decode of the state register, so an asynchronous
   // reset withdraws it immediately.
   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign pc_plus4  = fetch_pc + 32'd4;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_next          = state;
      pc_next             = pc;
      pending_next        = pending;
      pending_target_next = pending_target;
      fetch_valid_next    = 1'b0;
      fetch_pc_next       = fetch_pc;

      case (state)
         // IDLE and STALL differ only in why we are parked; both accept a
         // redirect directly into the PC since nothing is in flight.
         IDLE, STALL: begin
            if (redirect) pc_next = redirect_target;
            if (!stall)   state_next = en ? FETCH : IDLE;
         end

         FETCH: begin
            if (imem_ready) begin
               // A redirect in this cycle or one pending from earlier means
               // the fetch just completed is wrong-path: squash it.
               if (redirect) begin
                  pc_next = redirect_target;
               end else if (pending) begin
                  pc_next = pending_target;
               end else begin
                  pc_next          = pc + 32'd4;
                  fetch_valid_next = 1'b1;
                  fetch_pc_next    = pc;
               end
               pending_next = 1'b0;

               if (stall)    state_next = STALL;
               else if (!en) state_next = IDLE;
               else          state_next = FETCH;
            end else if (redirect) begin
               // The address must stay stable until accepted, so park the
               // target; a later redirect simply overwrites it.
               pending_next        = 1'b1;
               pending_target_next = redirect_target;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         pc             <= RESET_VECTOR;
         pending        <= 1'b0;
         pending_target <= 32'h0000_0000;
         fetch_valid    <= 1'b0;
         fetch_pc       <= RESET_VECTOR;
         misaligned     <= 1'b0;
      end else begin
         state          <= state_next;
         pc             <= pc_next;
         pending        <= pending_next;
         pending_target <= pending_target_next;
         fetch_valid    <= fetch_valid_next;
         fetch_pc       <= fetch_pc_next;
         misaligned     <= misaligned | (redirect & (|redirect_raw[1:0]));
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Directed bench for pc_fetch_sequencer. A behavioural model tracks only
// "is a request outstanding", the PC, a pending redirect and the sticky flag.
// A compare process checks the DUT against that model on every falling edge.
// Directed sequences also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        imem_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] pc_plus4;
   logic        misaligned;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .fetch_valid   (fetch_valid),
      .fetch_pc      (fetch_pc),
      .pc_plus4      (pc_plus4),
      .misaligned    (misaligned)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Parked-idle and parked-by-stall look identical from outside, so the model
   // only needs to know whether a request is outstanding.
   bit          m_busy, m_pend, m_fv, m_mis;
   logic [31:0] m_pc, m_pend_tgt, m_fpc;
   logic        m_redir;
   logic [31:0] m_raw, m_tgt;

   assign m_redir = jump | branch_taken;
   assign m_raw   = jump ? jump_target : branch_target;
   assign m_tgt   = m_raw & ~32'd3;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy     <= 1'b0;
         m_pend     <= 1'b0;
         m_fv       <= 1'b0;
         m_mis      <= 1'b0;
         m_pc       <= RV;
         m_pend_tgt <= 32'h0;
         m_fpc      <= RV;
      end else begin
         m_fv <= 1'b0;
         if (m_redir && m_raw[1:0] != 2'b00) m_mis <= 1'b1;
         if (!m_busy) begin
            if (m_redir) m_pc <= m_tgt;
            if (!stall)  m_busy <= en;
         end else if (imem_ready) begin
            m_pend <= 1'b0;
            m_busy <= en && !stall;
            if (m_redir)     m_pc <= m_tgt;
            else if (m_pend) m_pc <= m_pend_tgt;
            else begin
               m_fv  <= 1'b1;
               m_fpc <= m_pc;
               m_pc  <= m_pc + 32'd4;
            end
         end else if (m_redir) begin
            m_pend     <= 1'b1;
            m_pend_tgt <= m_tgt;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started && !reset) begin
         check("cmp_imem_req",    32'(imem_req),    32'(m_busy));
         check("cmp_imem_addr",   imem_addr,        m_pc);
         check("cmp_fetch_valid", 32'(fetch_valid), 32'(m_fv));
         check("cmp_misaligned",  32'(misaligned),  32'(m_mis));
         if (m_fv) begin
            check("cmp_fetch_pc", fetch_pc, m_fpc);
            check("cmp_pc_plus4", pc_plus4, m_fpc + 32'd4);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      en            = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      jump          = 1'b0;
      jump_target   = 32'h0;
      imem_ready    = 1'b0;
      #1;
      check("rst_imem_req",    32'(imem_req),    32'd0);
      check("rst_imem_addr",   imem_addr,        RV);
      check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst_fetch_pc",    fetch_pc,         RV);
      check("rst_pc_plus4",    pc_plus4,         RV + 32'd4);
      check("rst_misaligned",  32'(misaligned),  32'd0);
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      started = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();

      // A: back-to-back sequential fetches
      en = 1'b1; imem_ready = 1'b1;
      tick(); check("a_req", 32'(imem_req), 32'd1); check("a_addr0", imem_addr, 32'h0);
              check("a_fv_first", 32'(fetch_valid), 32'd0);
      tick(); check("a_addr4", imem_addr, 32'h4); check("a_fv", 32'(fetch_valid), 32'd1);
              check("a_fpc0", fetch_pc, 32'h0); check("a_p4_4", pc_plus4, 32'h4);
      tick(); check("a_addr8", imem_addr, 32'h8); check("a_fpc4", fetch_pc, 32'h4);
              check("a_p4_8", pc_plus4, 32'h8);
      tick(); check("a_addr12", imem_addr, 32'hC); check("a_fpc8", fetch_pc, 32'h8);
              check("a_p4_12", pc_plus4, 32'hC);

      // B: memory back-pressure at address 8
      do_reset();
      en = 1'b1; imem_ready = 1'b1;
      tick(); tick(); tick();
      check("b_addr8", imem_addr, 32'h8);
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("b_hold_addr", imem_addr, 32'h8);
         check("b_hold_fv", 32'(fetch_valid), 32'd0);
      end
      imem_ready = 1'b1;
      tick(); check("b_fv", 32'(fetch_valid), 32'd1); check("b_fpc8", fetch_pc, 32'h8);
              check("b_addr12", imem_addr, 32'hC);

      // C: branch then jump while fetch at 0x10 is outstanding
      tick(); check("c_addr10", imem_addr, 32'h10);
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
      tick(); check("c_hold1", imem_addr, 32'h10);
      branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h200;
      tick(); check("c_hold2", imem_addr, 32'h10); check("c_hold_fv", 32'(fetch_valid), 32'd0);
      jump = 1'b0; imem_ready = 1'b1;
      tick(); check("c_squash_fv", 32'(fetch_valid), 32'd0); check("c_addr200", imem_addr, 32'h200);
      tick(); check("c_fv200", 32'(fetch_valid), 32'd1); check("c_fpc200", fetch_pc, 32'h200);
              check("c_addr204", imem_addr, 32'h204);
      // redirect coinciding with a completion
      branch_taken = 1'b1; branch_target = 32'h300;
      tick(); check("c_cc_squash", 32'(fetch_valid), 32'd0); check("c_addr300", imem_addr, 32'h300);
      branch_taken = 1'b0;
      tick(); check("c_fpc300", fetch_pc, 32'h300);

      // D: jump beats branch in IDLE
      do_reset();
      jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
      tick(); check("d_idle_req", 32'(imem_req), 32'd0); check("d_idle_addr", imem_addr, 32'h40);
      jump = 1'b0; branch_taken = 1'b0; en = 1'b1; imem_ready = 1'b1;
      tick(); check("d_req", 32'(imem_req), 32'd1); check("d_addr40", imem_addr, 32'h40);
              check("d_mis0", 32'(misaligned), 32'd0);
      tick(); check("d_fpc40", fetch_pc, 32'h40);

      // D2: misaligned target is forced aligned and sets the sticky flag
      do_reset();
      branch_taken = 1'b1; branch_target = 32'h43; en = 1'b1;
      tick(); check("d2_addr40", imem_addr, 32'h40); check("d2_mis", 32'(misaligned), 32'd1);
              check("d2_req", 32'(imem_req), 32'd1);
      branch_taken = 1'b0;
      tick(); tick();
      check("d2_mis_sticky", 32'(misaligned), 32'd1); check("d2_addr_hold", imem_addr, 32'h40);

      // E: PC wrap-around
      do_reset();
      jump = 1'b1; jump_target = 32'hFFFF_FFFC; en = 1'b1; imem_ready = 1'b1;
      tick(); check("e_addr_top", imem_addr, 32'hFFFF_FFFC);
      jump = 1'b0;
      tick(); check("e_fv", 32'(fetch_valid), 32'd1); check("e_fpc", fetch_pc, 32'hFFFF_FFFC);
              check("e_p4_wrap", pc_plus4, 32'h0); check("e_addr_wrap", imem_addr, 32'h0);

      // F: stall during back-to-back fetches, then en drop
      tick(); check("f_addr4", imem_addr, 32'h4); check("f_fpc0", fetch_pc, 32'h0);
      stall = 1'b1;
      tick(); check("f_req_drop", 32'(imem_req), 32'd0); check("f_fv_inflight", 32'(fetch_valid), 32'd1);
              check("f_fpc4", fetch_pc, 32'h4); check("f_addr8", imem_addr, 32'h8);
      tick(); check("f_stalled_req", 32'(imem_req), 32'd0); check("f_stalled_fv", 32'(fetch_valid), 32'd0);
      tick(); check("f_stalled_req2", 32'(imem_req), 32'd0);
      stall = 1'b0;
      tick(); check("f_resume_req", 32'(imem_req), 32'd1); check("f_resume_addr", imem_addr, 32'h8);
      tick(); check("f_fpc8", fetch_pc, 32'h8); check("f_addr12", imem_addr, 32'hC);
      en = 1'b0;
      tick(); check("f_idle_req", 32'(imem_req), 32'd0); check("f_idle_fpc", fetch_pc, 32'hC);
      tick(); check("f_idle_req2", 32'(imem_req), 32'd0);

      // G: asynchronous reset abandons an outstanding request
      en = 1'b1; imem_ready = 1'b0;
      tick(); check("g_req_before", 32'(imem_req), 32'd1); check("g_addr_before", imem_addr, 32'h10);
      #2;
      do_reset();
      tick();
      check("g_after_req", 32'(imem_req), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
